// File: rtl/ysyx_23060203_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_pkg
// Shared definitions for the read-channel arbiter:
//   - state_t     : one-hot arbiter FSM states
//   - ARB_OWN_*   : owner encoding (0 = IFU, 1 = LSU)
//   - ARB_ID_*    : default AXI IDs driven on the shared arid
// ---------------------------------------------------------------------------
package ysyx_23060203_pkg;

  localparam int ARB_ID_W = 4;

  localparam logic [ARB_ID_W-1:0] ARB_ID_IFU_DEF = 4'd0;
  localparam logic [ARB_ID_W-1:0] ARB_ID_LSU_DEF = 4'd1;

  localparam logic ARB_OWN_IFU = 1'b0;
  localparam logic ARB_OWN_LSU = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_ADDR = 3'b010,
    ST_DATA = 3'b100
  } state_t;

endpackage

// File: rtl/ysyx_23060203_arb_pick.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_arb_pick
// Combinational winner selection between IFU (req[0]) and LSU (req[1]).
//   req  : request vector {lsu, ifu}
//   last : owner of the most recently completed burst (round-robin build)
//   gnt  : selected owner (ARB_OWN_IFU / ARB_OWN_LSU)
// Build option: YSYX_23060203_ARB_RR_EN selects round-robin on simultaneous
// requests; otherwise LSU has fixed priority over IFU. A lone requester
// always wins. gnt is only meaningful while at least one req bit is set.
// ---------------------------------------------------------------------------
module ysyx_23060203_arb_pick
  import ysyx_23060203_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

`ifdef YSYX_23060203_ARB_RR_EN
  // Round-robin: on a tie the requester that did not own the last burst wins.
  always_comb begin
    if (req == 2'b11) begin
      gnt = ~last;
    end else if (req[1]) begin
      gnt = ARB_OWN_LSU;
    end else begin
      gnt = ARB_OWN_IFU;
    end
  end
`else
  // Fixed priority ignores the history and the IFU bit by construction.
  logic [1:0] unused_bits;
  assign unused_bits = {last, req[0]};

  // Fixed priority: any LSU request wins.
  always_comb begin
    if (req[1]) begin
      gnt = ARB_OWN_LSU;
    end else begin
      gnt = ARB_OWN_IFU;
    end
  end
`endif

endmodule

// File: rtl/ysyx_23060203_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_rd_arbiter
// Two-master AXI read-channel arbiter: IFU (ICache refill) and LSU share one
// downstream read port. Ownership is granted in IDLE, held through the AR
// handshake and released only on the rlast beat of that burst.
// Ports:
//   clock, reset           : clock, synchronous active-low reset
//   ifu_* / lsu_*          : requester AR (arvalid/arready/araddr/arlen/
//                            arsize/arburst) and R (rvalid/rready/rdata/
//                            rlast/rresp) channels
//   mem_*                  : shared downstream AR/R channels, plus arid
//   perf_event_o           : contention pulse (non-owner requesting in ADDR)
// Build option: YSYX_23060203_ARB_RR_EN (round-robin tie-break, see
// ysyx_23060203_arb_pick). All forwarding is combinational from state/owner.
// ---------------------------------------------------------------------------
module ysyx_23060203_rd_arbiter
  import ysyx_23060203_pkg::*;
#(
  parameter logic [ARB_ID_W-1:0] ID_IFU = ARB_ID_IFU_DEF,
  parameter logic [ARB_ID_W-1:0] ID_LSU = ARB_ID_LSU_DEF
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read port
  input  logic                ifu_arvalid_i,
  output logic                ifu_arready_o,
  input  logic [31:0]         ifu_araddr_i,
  input  logic [7:0]          ifu_arlen_i,
  input  logic [2:0]          ifu_arsize_i,
  input  logic [1:0]          ifu_arburst_i,
  output logic                ifu_rvalid_o,
  input  logic                ifu_rready_i,
  output logic [63:0]         ifu_rdata_o,
  output logic                ifu_rlast_o,
  output logic [1:0]          ifu_rresp_o,
  // LSU read port
  input  logic                lsu_arvalid_i,
  output logic                lsu_arready_o,
  input  logic [31:0]         lsu_araddr_i,
  input  logic [7:0]          lsu_arlen_i,
  input  logic [2:0]          lsu_arsize_i,
  input  logic [1:0]          lsu_arburst_i,
  output logic                lsu_rvalid_o,
  input  logic                lsu_rready_i,
  output logic [63:0]         lsu_rdata_o,
  output logic                lsu_rlast_o,
  output logic [1:0]          lsu_rresp_o,
  // Shared downstream read port
  output logic                mem_arvalid_o,
  input  logic                mem_arready_i,
  output logic [31:0]         mem_araddr_o,
  output logic [7:0]          mem_arlen_o,
  output logic [2:0]          mem_arsize_o,
  output logic [1:0]          mem_arburst_o,
  output logic [ARB_ID_W-1:0] mem_arid_o,
  input  logic                mem_rvalid_i,
  output logic                mem_rready_o,
  input  logic [63:0]         mem_rdata_i,
  input  logic                mem_rlast_i,
  input  logic [1:0]          mem_rresp_i,
  // Performance hook
  output logic                perf_event_o
);

  state_t state_q;
  logic   own_q;
  logic   pick_last;
  logic   pick_gnt;
  logic   in_addr;
  logic   in_data;
  logic   own_arvalid;
  logic   own_rready;
  logic   other_arvalid;

`ifdef YSYX_23060203_ARB_RR_EN
  logic last_q;
  assign pick_last = last_q;
`else
  assign pick_last = 1'b1;
`endif

  ysyx_23060203_arb_pick u_pick (
    .req  ({lsu_arvalid_i, ifu_arvalid_i}),
    .last (pick_last),
    .gnt  (pick_gnt)
  );

  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);

  // Arbiter FSM: grant in IDLE, hold owner until the rlast handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      own_q   <= ARB_OWN_IFU;
`ifdef YSYX_23060203_ARB_RR_EN
      last_q  <= ARB_OWN_LSU;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ifu_arvalid_i || lsu_arvalid_i) begin
            own_q   <= pick_gnt;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (mem_arvalid_o && mem_arready_i) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_rvalid_i && mem_rready_o && mem_rlast_i) begin
            state_q <= ST_IDLE;
`ifdef YSYX_23060203_ARB_RR_EN
            last_q  <= own_q;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Owner-side AR mux; arid identifies the owner to the downstream port.
  always_comb begin
    if (own_q == ARB_OWN_LSU) begin
      own_arvalid   = lsu_arvalid_i;
      own_rready    = lsu_rready_i;
      other_arvalid = ifu_arvalid_i;
      mem_araddr_o  = lsu_araddr_i;
      mem_arlen_o   = lsu_arlen_i;
      mem_arsize_o  = lsu_arsize_i;
      mem_arburst_o = lsu_arburst_i;
      mem_arid_o    = ID_LSU;
    end else begin
      own_arvalid   = ifu_arvalid_i;
      own_rready    = ifu_rready_i;
      other_arvalid = lsu_arvalid_i;
      mem_araddr_o  = ifu_araddr_i;
      mem_arlen_o   = ifu_arlen_i;
      mem_arsize_o  = ifu_arsize_i;
      mem_arburst_o = ifu_arburst_i;
      mem_arid_o    = ID_IFU;
    end
  end

  assign mem_arvalid_o = in_addr & own_arvalid;
  assign mem_rready_o  = in_data & own_rready;

  // Return path: only the owner sees arready/R traffic; the other side reads 0.
  always_comb begin
    ifu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    ifu_rdata_o   = 64'd0;
    ifu_rlast_o   = 1'b0;
    ifu_rresp_o   = 2'd0;
    lsu_arready_o = 1'b0;
    lsu_rvalid_o  = 1'b0;
    lsu_rdata_o   = 64'd0;
    lsu_rlast_o   = 1'b0;
    lsu_rresp_o   = 2'd0;
    if (own_q == ARB_OWN_LSU) begin
      lsu_arready_o = in_addr & mem_arready_i;
      if (in_data) begin
        lsu_rvalid_o = mem_rvalid_i;
        lsu_rdata_o  = mem_rdata_i;
        lsu_rlast_o  = mem_rlast_i;
        lsu_rresp_o  = mem_rresp_i;
      end else begin
        lsu_rvalid_o = 1'b0;
      end
    end else begin
      ifu_arready_o = in_addr & mem_arready_i;
      if (in_data) begin
        ifu_rvalid_o = mem_rvalid_i;
        ifu_rdata_o  = mem_rdata_i;
        ifu_rlast_o  = mem_rlast_i;
        ifu_rresp_o  = mem_rresp_i;
      end else begin
        ifu_rvalid_o = 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  assign perf_event_o = in_addr & other_arvalid;

  // An owner must keep arvalid up until its AR handshake.
  a_ar_hold: assert property (@(posedge clock) disable iff (!reset)
                              in_addr |-> own_arvalid);
`else
  assign perf_event_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060203_rd_arbiter.sv
`timescale 1ns/1ps
module tb_ysyx_23060203_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        ifu_arvalid = 1'b0, ifu_arready, ifu_rvalid, ifu_rready = 1'b0, ifu_rlast;
  logic [31:0] ifu_araddr = 32'd0;
  logic [7:0]  ifu_arlen = 8'd0;
  logic [2:0]  ifu_arsize = 3'd0;
  logic [1:0]  ifu_arburst = 2'd0, ifu_rresp;
  logic [63:0] ifu_rdata;
  logic        lsu_arvalid = 1'b0, lsu_arready, lsu_rvalid, lsu_rready = 1'b0, lsu_rlast;
  logic [31:0] lsu_araddr = 32'd0;
  logic [7:0]  lsu_arlen = 8'd0;
  logic [2:0]  lsu_arsize = 3'd0;
  logic [1:0]  lsu_arburst = 2'd0, lsu_rresp;
  logic [63:0] lsu_rdata;
  logic        mem_arvalid, mem_arready = 1'b0, mem_rvalid = 1'b0, mem_rready, mem_rlast = 1'b0;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst, mem_rresp = 2'd0;
  logic [3:0]  mem_arid;
  logic [63:0] mem_rdata = 64'd0;
  logic        perf_event;

  ysyx_23060203_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready), .ifu_araddr_i(ifu_araddr),
    .ifu_arlen_i(ifu_arlen), .ifu_arsize_i(ifu_arsize), .ifu_arburst_i(ifu_arburst),
    .ifu_rvalid_o(ifu_rvalid), .ifu_rready_i(ifu_rready), .ifu_rdata_o(ifu_rdata),
    .ifu_rlast_o(ifu_rlast), .ifu_rresp_o(ifu_rresp),
    .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready), .lsu_araddr_i(lsu_araddr),
    .lsu_arlen_i(lsu_arlen), .lsu_arsize_i(lsu_arsize), .lsu_arburst_i(lsu_arburst),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rready_i(lsu_rready), .lsu_rdata_o(lsu_rdata),
    .lsu_rlast_o(lsu_rlast), .lsu_rresp_o(lsu_rresp),
    .mem_arvalid_o(mem_arvalid), .mem_arready_i(mem_arready), .mem_araddr_o(mem_araddr),
    .mem_arlen_o(mem_arlen), .mem_arsize_o(mem_arsize), .mem_arburst_o(mem_arburst),
    .mem_arid_o(mem_arid), .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready),
    .mem_rdata_i(mem_rdata), .mem_rlast_i(mem_rlast), .mem_rresp_i(mem_rresp),
    .perf_event_o(perf_event)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction-level reference: who owns the port, and whether its AR is done.
  int m_owner = -1;       // -1 none, 0 IFU, 1 LSU
  bit m_addr_done = 1'b0;
  int m_last = 1;         // owner of last completed burst

  // Stimulus agents
  int          req_left[2];
  int          cfg_len[2];
  logic [31:0] cfg_addr[2];
  bit          rr_rand = 1'b0, ar_rand = 1'b0, r_rand = 1'b0;
  bit          mem_busy = 1'b0;
  int          beats_left = 0;

  // Observation logs
  int          grant_log[$];
  logic [31:0] last_ar_addr = 32'd0;
  int          ifu_last_cyc = -100, lsu_ar_cyc = -100;
  int          beats[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [1:0] r);
    if (r == 2'b11) begin
`ifdef YSYX_23060203_ARB_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    return r[1] ? 1 : 0;
  endfunction

  function automatic logic [31:0] next_addr(input int i);
    return (cfg_addr[i] != 32'd0) ? cfg_addr[i] : ($urandom & 32'hFFFF_FFF8);
  endfunction

  function automatic logic [7:0] next_len(input int i);
    return (cfg_len[i] < 0) ? 8'($urandom_range(0, 3)) : 8'(cfg_len[i]);
  endfunction

  // One clock: check outputs at negedge, advance model at posedge, drive agents.
  task automatic tick();
    bit [1:0] arv, rdy;
    bit own_any, done, ex_arv, ex_ar_hs, ex_r_hs;
    int own;
    bit ar_hs_i, ar_hs_l, mem_ar_hs, r_hs_i, r_hs_l, rst_now, rlast_s, rvalid_s, arready_s;
    logic [7:0] len_s;
    @(negedge clock);
    arv = {lsu_arvalid, ifu_arvalid};
    rdy = {lsu_rready, ifu_rready};
    own_any = (m_owner >= 0);
    own  = (m_owner > 0) ? 1 : 0;
    done = m_addr_done;
    ex_arv = own_any && !done && arv[own];
    chk("mem_arvalid", mem_arvalid, ex_arv);
    if (ex_arv) begin
      chk("mem_araddr", mem_araddr, own ? lsu_araddr : ifu_araddr);
      chk("mem_arlen", mem_arlen, own ? lsu_arlen : ifu_arlen);
      chk("mem_arid", mem_arid, 64'(own));
    end
    chk("ifu_arready", ifu_arready, own_any && own == 0 && !done && mem_arready);
    chk("lsu_arready", lsu_arready, own_any && own == 1 && !done && mem_arready);
    chk("ifu_rvalid", ifu_rvalid, own_any && own == 0 && done && mem_rvalid);
    chk("lsu_rvalid", lsu_rvalid, own_any && own == 1 && done && mem_rvalid);
    chk("ifu_rdata", ifu_rdata, (own_any && own == 0 && done) ? mem_rdata : 64'd0);
    chk("lsu_rdata", lsu_rdata, (own_any && own == 1 && done) ? mem_rdata : 64'd0);
    chk("ifu_rlast", ifu_rlast, own_any && own == 0 && done && mem_rlast);
    chk("lsu_rlast", lsu_rlast, own_any && own == 1 && done && mem_rlast);
    chk("mem_rready", mem_rready, own_any && done && rdy[own]);
    chk("perf_event", perf_event, own_any && !done && arv[1-own]);

    ar_hs_i   = ifu_arvalid && ifu_arready;
    ar_hs_l   = lsu_arvalid && lsu_arready;
    mem_ar_hs = mem_arvalid && mem_arready;
    r_hs_i    = ifu_rvalid && ifu_rready;
    r_hs_l    = lsu_rvalid && lsu_rready;
    if (mem_ar_hs) begin
      grant_log.push_back(int'(mem_arid));
      last_ar_addr = mem_araddr;
    end
    if (r_hs_i && ifu_rlast) ifu_last_cyc = cyc;
    if (ar_hs_l) lsu_ar_cyc = cyc;
    if (r_hs_i) beats[0]++;
    if (r_hs_l) beats[1]++;
    rst_now   = reset;
    rlast_s   = mem_rlast;
    rvalid_s  = mem_rvalid;
    arready_s = mem_arready;
    len_s     = mem_arlen;
    ex_ar_hs  = ex_arv && arready_s;
    ex_r_hs   = own_any && done && rvalid_s && rdy[own];

    @(posedge clock);
    cyc++;
    if (!rst_now) begin
      m_owner = -1; m_addr_done = 1'b0; m_last = 1;
    end else if (!own_any) begin
      if (arv != 2'b00) begin m_owner = pick(arv); m_addr_done = 1'b0; end
    end else if (!done) begin
      if (ex_ar_hs) m_addr_done = 1'b1;
    end else if (ex_r_hs && rlast_s) begin
      m_last = m_owner; m_owner = -1;
    end

    #1;
    if (!rst_now) begin
      ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_busy = 1'b0; beats_left = 0;
    end else begin
      if (ar_hs_i) ifu_arvalid = 1'b0;
      if (ar_hs_l) lsu_arvalid = 1'b0;
      if (!ifu_arvalid && req_left[0] > 0) begin
        ifu_arvalid = 1'b1; ifu_araddr = next_addr(0); ifu_arlen = next_len(0);
        ifu_arsize = 3'd3; ifu_arburst = 2'd1; req_left[0]--;
      end
      if (!lsu_arvalid && req_left[1] > 0) begin
        lsu_arvalid = 1'b1; lsu_araddr = next_addr(1); lsu_arlen = next_len(1);
        lsu_arsize = 3'd3; lsu_arburst = 2'd1; req_left[1]--;
      end
      if (mem_ar_hs) begin mem_busy = 1'b1; beats_left = int'(len_s) + 1; end
      if (rvalid_s && mem_rready) begin end
      if (r_hs_i || r_hs_l) begin
        beats_left--; mem_rvalid = 1'b0;
        if (beats_left == 0) mem_busy = 1'b0;
      end
      if (mem_busy && !mem_rvalid && (!r_rand || $urandom_range(0, 1) == 1)) begin
        mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
        mem_rlast = (beats_left == 1); mem_rresp = 2'($urandom_range(0, 3));
      end
      if (!mem_rvalid) mem_rlast = 1'b0;
    end
    ifu_rready  = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    lsu_rready  = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((req_left[0] > 0 || req_left[1] > 0 || ifu_arvalid || lsu_arvalid ||
            m_owner >= 0 || mem_busy) && k < budget) begin
      tick(); k++;
    end
    n_cmp++;
    assert (k < budget) else begin
      n_bad++;
      $error("FAIL drain_timeout observed=%0d expected<%0d", k, budget);
    end
    tick();
  endtask

  int g0, b0, b1, k;

  initial begin
    req_left[0] = 0; req_left[1] = 0;
    cfg_len[0] = -1; cfg_len[1] = -1;
    cfg_addr[0] = 32'd0; cfg_addr[1] = 32'd0;
    beats[0] = 0; beats[1] = 0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_arvalid", mem_arvalid, 1'b0);
    chk("rst_mem_rready", mem_rready, 1'b0);
    chk("rst_ifu_arready", ifu_arready, 1'b0);
    chk("rst_lsu_arready", lsu_arready, 1'b0);
    chk("rst_ifu_rvalid", ifu_rvalid, 1'b0);
    chk("rst_lsu_rvalid", lsu_rvalid, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // IFU only, 2-beat burst at a fixed address
    g0 = grant_log.size(); b0 = beats[0]; b1 = beats[1];
    cfg_addr[0] = 32'h8000_0010; cfg_len[0] = 1; req_left[0] = 1;
    drain(200);
    chk("t1_grants", grant_log.size() - g0, 1);
    if (grant_log.size() > g0) chk("t1_arid", grant_log[g0], 0);
    chk("t1_araddr", last_ar_addr, 32'h8000_0010);
    chk("t1_ifu_beats", beats[0] - b0, 2);
    chk("t1_lsu_beats", beats[1] - b1, 0);

    // LSU only, single beat
    g0 = grant_log.size(); b0 = beats[0]; b1 = beats[1];
    cfg_addr[1] = 32'hA000_0000; cfg_len[1] = 0; req_left[1] = 1;
    drain(200);
    if (grant_log.size() > g0) chk("t2_arid", grant_log[g0], 1);
    chk("t2_araddr", last_ar_addr, 32'hA000_0000);
    chk("t2_lsu_beats", beats[1] - b1, 1);
    chk("t2_ifu_beats", beats[0] - b0, 0);
    cfg_addr[0] = 32'd0; cfg_addr[1] = 32'd0;

    // Simultaneous single requests
    g0 = grant_log.size();
    cfg_len[0] = 2; cfg_len[1] = 1; req_left[0] = 1; req_left[1] = 1;
    drain(300);
    chk("t3_grants", grant_log.size() - g0, 2);
    if (grant_log.size() >= g0 + 2) begin
`ifdef YSYX_23060203_ARB_RR_EN
      chk("t3_first", grant_log[g0], 0);
      chk("t3_second", grant_log[g0+1], 1);
`else
      chk("t3_first", grant_log[g0], 1);
      chk("t3_second", grant_log[g0+1], 0);
`endif
    end

    // Both re-requesting for 4 bursts
    g0 = grant_log.size();
    cfg_len[0] = -1; cfg_len[1] = -1; req_left[0] = 2; req_left[1] = 2;
    drain(400);
    chk("t4_grants", grant_log.size() - g0, 4);
    if (grant_log.size() >= g0 + 4) begin
`ifdef YSYX_23060203_ARB_RR_EN
      chk("t4_order", {grant_log[g0], grant_log[g0+1], grant_log[g0+2], grant_log[g0+3]}, {32'd0, 32'd1, 32'd0, 32'd1});
`else
      chk("t4_order", {grant_log[g0], grant_log[g0+1], grant_log[g0+2], grant_log[g0+3]}, {32'd1, 32'd1, 32'd0, 32'd0});
`endif
    end

    // LSU waits behind a 4-beat IFU burst with rready toggling
    g0 = grant_log.size(); b0 = beats[0];
    rr_rand = 1'b1; r_rand = 1'b1;
    cfg_len[0] = 3; cfg_len[1] = 0; req_left[0] = 1;
    repeat (3) tick();
    req_left[1] = 1;
    drain(300);
    chk("t5_ifu_beats", beats[0] - b0, 4);
    if (grant_log.size() >= g0 + 2) chk("t5_order", {grant_log[g0], grant_log[g0+1]}, {32'd0, 32'd1});
    chk("t5_turnaround", lsu_ar_cyc - ifu_last_cyc, 2);

    // Reset during beat 2 of 4
    rr_rand = 1'b0; r_rand = 1'b0;
    b0 = beats[0]; cfg_len[0] = 3; req_left[0] = 1;
    k = 0;
    while (beats[0] - b0 < 1 && k < 50) begin tick(); k++; end
    chk("t6_reached_beat2", beats[0] - b0, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_mem_arvalid", mem_arvalid, 1'b0);
    chk("t6_mem_rready", mem_rready, 1'b0);
    chk("t6_ifu_rvalid", ifu_rvalid, 1'b0);
    chk("t6_lsu_rvalid", lsu_rvalid, 1'b0);
    tick();
    b0 = beats[0]; g0 = grant_log.size();
    cfg_len[0] = 1; req_left[0] = 1;
    drain(200);
    chk("t6_after_beats", beats[0] - b0, 2);
    chk("t6_after_grants", grant_log.size() - g0, 1);

    // Randomized mixed traffic
    rr_rand = 1'b1; ar_rand = 1'b1; r_rand = 1'b1;
    cfg_len[0] = -1; cfg_len[1] = -1;
    b0 = beats[0]; b1 = beats[1]; g0 = grant_log.size();
    req_left[0] = $urandom_range(5, 15);
    req_left[1] = $urandom_range(5, 15);
    k = req_left[0] + req_left[1];
    drain(5000);
    chk("rand_grants", grant_log.size() - g0, k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
